// File: rtl/alu_pkg.sv
// alu_pkg: shared slice width and sequencer state encoding for the ALU datapath.
package alu_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/sub_slice_4bit.sv
// sub_slice_4bit: 4-bit look-ahead slice computing a + ~b + cin.
module sub_slice_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] p, g;
    logic       c1, c2, c3;
    assign p = a ^ ~b;
    assign g = a & ~b;
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/multiword_subtractor_seq.sv
// multiword_subtractor_seq: diff = a - b - bin, one 4-bit slice per clock, LSB first.
// Operands shift right each cycle so the active slice is always at bits [3:0].
module multiword_subtractor_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW = $clog2(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (WIDTH % SLICE_W != 0 || WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 8");
    end

    state_t           state, state_nx;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] a_q, b_q, diff_nx;
    logic [SLICE_W-1:0] s;
    logic             carry, c4, accept, last;

    sub_slice_4bit u_slice (
        .a    (a_q[SLICE_W-1:0]),
        .b    (b_q[SLICE_W-1:0]),
        .cin  (carry),
        .s    (s),
        .cout (c4)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign last      = state == BUSY && idx == LAST;
    // New slice enters at the top; after NSLICE shifts every slice sits in place.
    assign diff_nx   = {s, diff[WIDTH-1:SLICE_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept)                          state_nx = BUSY;
        else if (last)                       state_nx = DONE;
        else if (state == DONE && out_ready) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ~bin;
            idx   <= '0;
        end else if (state == BUSY) begin
            a_q   <= a_q >> SLICE_W;
            b_q   <= b_q >> SLICE_W;
            carry <= c4;
            idx   <= idx + 1'b1;
            diff  <= diff_nx;
            if (last) begin
                borrow_out <= ~c4;
                overflow   <= (a_q[SLICE_W-1] ^ b_q[SLICE_W-1]) & (s[SLICE_W-1] ^ a_q[SLICE_W-1]);
                zero       <= diff_nx == '0;
            end
        end
    end
endmodule
